// File: rtl/ra_writer_pkg.sv
// Shared Region Array definitions: control-word bit positions, marker words, list indices,
// OPB sizing and the writer FSM state type.
package ra_writer_pkg;

  localparam int unsigned NumLists = 5;
  localparam int unsigned ListO    = 0;
  localparam int unsigned ListPt   = 4;

  localparam int unsigned CtrlLastBit  = 31;
  localparam int unsigned CtrlZclrBit  = 30;
  localparam int unsigned CtrlFlushBit = 28;

  localparam logic [31:0] RaPtrUnused = 32'h8000_0000;
  localparam logic [31:0] OlEolWord   = 32'hF000_0000;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StCtrl,
    StPtr,
    StOlInit,
    StNext,
    StDone
  } state_e;

  // n = 1..3 gives 32/64/128 bytes; n = 0 means the list is off and is gated by the caller.
  function automatic logic [23:0] opb_bytes(input logic [1:0] n);
    return 24'd16 << n;
  endfunction

endpackage

// File: rtl/ra_writer.sv
// Region Array writer: one control word plus 4 (v1) or 5 (v2) list pointers per tile.
// Optional feature: define RA_WRITER_OL_INIT_EN to seed each enabled OPB with an EOL link word.
module ra_writer
  import ra_writer_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ra_gen_trig,
  input  logic [31:0] REGION_BASE,
  input  logic [31:0] OL_BASE,
  input  logic [31:0] TA_ALLOC_CTRL,
  input  logic [31:0] FPU_PARAM_CFG,
  input  logic [5:0]  tiles_x_m1,
  input  logic [5:0]  tiles_y_m1,
  input  logic        zclear_flag,
  output logic        ra_vram_wr,
  output logic [23:0] ra_vram_addr,
  output logic [31:0] ra_vram_dout,
  input  logic        ra_vram_wait,
  output logic        ra_gen_busy,
  output logic        ra_gen_done,
  output logic [12:0] ra_entry_cnt
);

  state_e                     state_q, state_d;
  logic [2:0]                 li_q, li_d;
  logic [23:0]                sum_q, sum_d;
  logic [NumLists-1:0][23:0]  ptr_q, ptr_d;
  logic [NumLists-1:0][1:0]   opb_q, opb_d;
  logic                       v2_q, v2_d;
  logic                       zc_q, zc_d;
  logic [5:0]                 tx_q, tx_d, ty_q, ty_d;
  logic [5:0]                 x_q, x_d, y_q, y_d;
  logic [23:0]                ra_addr_q, ra_addr_d;
  logic [12:0]                cnt_q, cnt_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       wr_q, wr_d;
  logic [23:0]                addr_q, addr_d;
  logic [31:0]                dout_q, dout_d;

  logic [NumLists-1:0] en;
  logic [12:0]         num_tiles;
  logic                accept;
  logic                last_tile;
  logic [3:0]          nxt;
  logic                unused_ok;

  assign unused_ok = ^{REGION_BASE[31:24], OL_BASE[31:24], TA_ALLOC_CTRL[31:18],
                       TA_ALLOC_CTRL[15:14], TA_ALLOC_CTRL[11:10], TA_ALLOC_CTRL[7:6],
                       TA_ALLOC_CTRL[3:2], FPU_PARAM_CFG[31:22], FPU_PARAM_CFG[20:0]};

  // Returns {found, index} of the first enabled list at or above `from`.
  function automatic logic [3:0] next_en(input logic [NumLists-1:0] mask, input logic [2:0] from);
    logic [3:0] r;
    r = '0;
    for (int i = NumLists - 1; i >= 0; i--) begin
      if (i >= int'(from) && mask[i]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  function automatic logic [31:0] ctrl_word(input logic last, input logic zc,
                                            input logic [5:0] x, input logic [5:0] y);
    logic [31:0] w;
    w               = '0;
    w[CtrlLastBit]  = last;
    w[CtrlZclrBit]  = zc;
    w[CtrlFlushBit] = 1'b0;
    w[13:8]         = y;
    w[7:2]          = x;
    return w;
  endfunction

  always_comb begin
    for (int l = 0; l < NumLists; l++) en[l] = |opb_q[l];
  end

  assign num_tiles = (13'(tx_q) + 13'd1) * (13'(ty_q) + 13'd1);
  assign accept    = wr_q && !ra_vram_wait;
  assign last_tile = (x_q == tx_q) && (y_q == ty_q);

  always_comb begin
    state_d   = state_q;
    li_d      = li_q;
    sum_d     = sum_q;
    ptr_d     = ptr_q;
    opb_d     = opb_q;
    v2_d      = v2_q;
    zc_d      = zc_q;
    tx_d      = tx_q;
    ty_d      = ty_q;
    x_d       = x_q;
    y_d       = y_q;
    ra_addr_d = ra_addr_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    nxt       = '0;

    unique case (state_q)
      StIdle: begin
        if (ra_gen_trig) begin
          for (int l = 0; l < NumLists; l++) opb_d[l] = TA_ALLOC_CTRL[4*l +: 2];
          v2_d      = FPU_PARAM_CFG[21];
          zc_d      = zclear_flag;
          tx_d      = tiles_x_m1;
          ty_d      = tiles_y_m1;
          ra_addr_d = REGION_BASE[23:0];
          sum_d     = OL_BASE[23:0];
          li_d      = 3'(ListO);
          x_d       = '0;
          y_d       = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = StSetup;
        end
      end
      // One list per cycle: its OPB area starts at the running sum of the earlier areas.
      StSetup: begin
        ptr_d[li_q] = sum_q;
        if (en[li_q]) sum_d = sum_q + (24'(num_tiles) << (3'd4 + {1'b0, opb_q[li_q]}));
        if (li_q == 3'(ListPt)) begin
          li_d    = 3'(ListO);
          state_d = StCtrl;
        end else begin
          li_d = li_q + 3'd1;
        end
      end
      StCtrl: begin
        if (accept) begin
          ra_addr_d = ra_addr_q + 24'd4;
          li_d      = 3'(ListO);
          state_d   = StPtr;
        end
      end
      StPtr: begin
        if (accept) begin
          ra_addr_d = ra_addr_q + 24'd4;
          if (li_q == (v2_q ? 3'd4 : 3'd3)) begin
`ifdef RA_WRITER_OL_INIT_EN
            nxt = next_en(en, 3'd0);
            if (nxt[3]) begin
              li_d    = nxt[2:0];
              state_d = StOlInit;
            end else begin
              state_d = StNext;
            end
`else
            state_d = StNext;
`endif
          end else begin
            li_d = li_q + 3'd1;
          end
        end
      end
      StOlInit: begin
        if (accept) begin
          nxt = next_en(en, li_q + 3'd1);
          if (nxt[3]) li_d = nxt[2:0];
          else        state_d = StNext;
        end
      end
      StNext: begin
        cnt_d = cnt_q + 13'd1;
        for (int l = 0; l < NumLists; l++) begin
          if (en[l]) ptr_d[l] = ptr_q[l] + opb_bytes(opb_q[l]);
        end
        if (last_tile) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          if (x_q == tx_q) begin
            x_d = '0;
            y_d = y_q + 6'd1;
          end else begin
            x_d = x_q + 6'd1;
          end
          state_d = StCtrl;
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Write port is registered: present the word belonging to the state being entered.
    wr_d   = 1'b0;
    addr_d = '0;
    dout_d = '0;
    unique case (state_d)
      StCtrl: begin
        wr_d   = 1'b1;
        addr_d = ra_addr_d;
        dout_d = ctrl_word((x_d == tx_d) && (y_d == ty_d), zc_d, x_d, y_d);
      end
      StPtr: begin
        wr_d   = 1'b1;
        addr_d = ra_addr_d;
        dout_d = en[li_d] ? {8'h00, ptr_d[li_d]} : RaPtrUnused;
      end
      StOlInit: begin
        wr_d   = 1'b1;
        addr_d = ptr_d[li_d];
        dout_d = OlEolWord;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      li_q      <= '0;
      sum_q     <= '0;
      ptr_q     <= '0;
      opb_q     <= '0;
      v2_q      <= 1'b0;
      zc_q      <= 1'b0;
      tx_q      <= '0;
      ty_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      ra_addr_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      li_q      <= li_d;
      sum_q     <= sum_d;
      ptr_q     <= ptr_d;
      opb_q     <= opb_d;
      v2_q      <= v2_d;
      zc_q      <= zc_d;
      tx_q      <= tx_d;
      ty_q      <= ty_d;
      x_q       <= x_d;
      y_q       <= y_d;
      ra_addr_q <= ra_addr_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
    end
  end

  assign ra_vram_wr   = wr_q;
  assign ra_vram_addr = addr_q;
  assign ra_vram_dout = dout_q;
  assign ra_gen_busy  = busy_q;
  assign ra_gen_done  = done_q;
  assign ra_entry_cnt = cnt_q;

endmodule

// File: tb/tb_ra_writer.sv
// Randomised bench for ra_writer: a list-level model of the RA/OPB layout feeds an expected
// write queue that a single negedge monitor compares against every accepted VRAM write.
module tb_ra_writer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ra_gen_trig;
  logic [31:0] REGION_BASE, OL_BASE, TA_ALLOC_CTRL, FPU_PARAM_CFG;
  logic [5:0]  tiles_x_m1, tiles_y_m1;
  logic        zclear_flag;
  logic        ra_vram_wr;
  logic [23:0] ra_vram_addr;
  logic [31:0] ra_vram_dout;
  logic        ra_vram_wait;
  logic        ra_gen_busy;
  logic        ra_gen_done;
  logic [12:0] ra_entry_cnt;

  ra_writer dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .ra_gen_trig  (ra_gen_trig),
    .REGION_BASE  (REGION_BASE),
    .OL_BASE      (OL_BASE),
    .TA_ALLOC_CTRL(TA_ALLOC_CTRL),
    .FPU_PARAM_CFG(FPU_PARAM_CFG),
    .tiles_x_m1   (tiles_x_m1),
    .tiles_y_m1   (tiles_y_m1),
    .zclear_flag  (zclear_flag),
    .ra_vram_wr   (ra_vram_wr),
    .ra_vram_addr (ra_vram_addr),
    .ra_vram_dout (ra_vram_dout),
    .ra_vram_wait (ra_vram_wait),
    .ra_gen_busy  (ra_gen_busy),
    .ra_gen_done  (ra_gen_done),
    .ra_entry_cnt (ra_entry_cnt)
  );

  initial forever #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  logic [23:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [23:0] got_addr[$];
  logic [31:0] got_data[$];
  int          exp_entries = 0;
  int          exp_words   = 0;
  int          acc_cnt     = 0;
  int          done_cnt    = 0;
  int          stall_cnt   = 0;
  int          wait_mode   = 0;
  int          stall_n     = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Whole-frame model: OPB area bases are prefix sums of tiles*size, pointers are base+tile*size.
  task automatic build_model(input logic [5:0] tx, input logic [5:0] ty, input logic [23:0] rb,
                             input logic [23:0] ob, input logic [9:0] nsz, input bit v2,
                             input bit zc);
    int          nt, w, nl;
    logic [23:0] base[5];
    logic [23:0] sum, ra, p;
    logic [31:0] ctrl;
    nt  = (int'(tx) + 1) * (int'(ty) + 1);
    w   = int'(tx) + 1;
    nl  = v2 ? 5 : 4;
    sum = ob;
    for (int l = 0; l < 5; l++) begin
      base[l] = sum;
      if (nsz[2*l +: 2] != 2'd0) sum = sum + 24'(nt * (16 << nsz[2*l +: 2]));
    end
    exp_addr_q.delete();
    exp_data_q.delete();
    ra = rb;
    for (int t = 0; t < nt; t++) begin
      ctrl = ((t == nt - 1) ? 32'h8000_0000 : 32'h0) | (zc ? 32'h4000_0000 : 32'h0) |
             (32'(t / w) << 8) | (32'(t % w) << 2);
      exp_addr_q.push_back(ra);
      exp_data_q.push_back(ctrl);
      ra = ra + 24'd4;
      for (int l = 0; l < nl; l++) begin
        p = base[l] + 24'(t * (16 << nsz[2*l +: 2]));
        exp_addr_q.push_back(ra);
        exp_data_q.push_back((nsz[2*l +: 2] != 2'd0) ? {8'h00, p} : 32'h8000_0000);
        ra = ra + 24'd4;
      end
`ifdef RA_WRITER_OL_INIT_EN
      for (int l = 0; l < 5; l++) begin
        if (nsz[2*l +: 2] != 2'd0) begin
          exp_addr_q.push_back(base[l] + 24'(t * (16 << nsz[2*l +: 2])));
          exp_data_q.push_back(32'hF000_0000);
        end
      end
`endif
    end
    exp_entries = nt;
    exp_words   = exp_addr_q.size();
  endtask

  // Compare process: every accepted write, stall stability and done pulses.
  logic        prev_stall = 1'b0;
  logic [23:0] prev_addr;
  logic [31:0] prev_dout;
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_addr", 64'(ra_vram_addr), 64'(prev_addr));
        check("stall_data", 64'(ra_vram_dout), 64'(prev_dout));
        check("stall_wr", 64'(ra_vram_wr), 64'd1);
      end
      prev_stall = ra_vram_wr && ra_vram_wait;
      prev_addr  = ra_vram_addr;
      prev_dout  = ra_vram_dout;
      if (ra_vram_wr && ra_vram_wait) stall_cnt++;
      if (ra_vram_wr && !ra_vram_wait) begin
        acc_cnt++;
        got_addr.push_back(ra_vram_addr);
        got_data.push_back(ra_vram_dout);
        if (exp_addr_q.size() == 0) begin
          check("extra_write", 64'(ra_vram_addr), 64'hDEAD);
        end else begin
          check("wr_addr", 64'(ra_vram_addr), 64'(exp_addr_q.pop_front()));
          check("wr_data", 64'(ra_vram_dout), 64'(exp_data_q.pop_front()));
        end
      end
      if (ra_gen_done) begin
        done_cnt++;
        check("done_entry_cnt", 64'(ra_entry_cnt), 64'(exp_entries));
      end
    end
  end

  initial begin
    ra_vram_wait = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (wait_mode)
        1: ra_vram_wait = ($urandom_range(0, 3) == 0);
        2: begin
          if (acc_cnt == 2 && stall_n < 3) begin
            ra_vram_wait = 1'b1;
            stall_n++;
          end else begin
            ra_vram_wait = 1'b0;
          end
        end
        default: ra_vram_wait = 1'b0;
      endcase
    end
  end

  task automatic run_frame(input logic [5:0] tx, input logic [5:0] ty, input logic [23:0] rb,
                           input logic [23:0] ob, input logic [9:0] nsz, input bit v2,
                           input bit zc, input int wmode, input bit retrig, input int abort_at);
    logic [31:0] ta;
    int          budget;
    build_model(tx, ty, rb, ob, nsz, v2, zc);
    ta = $urandom() & ~32'h0003_3333;
    for (int l = 0; l < 5; l++) ta[4*l +: 2] = nsz[2*l +: 2];
    acc_cnt   = 0;
    done_cnt  = 0;
    stall_cnt = 0;
    stall_n   = 0;
    got_addr.delete();
    got_data.delete();
    @(negedge clock);
    REGION_BASE   = {8'($urandom()), rb};
    OL_BASE       = {8'($urandom()), ob};
    TA_ALLOC_CTRL = ta;
    FPU_PARAM_CFG = ($urandom() & ~32'h0020_0000) | (v2 ? 32'h0020_0000 : 32'h0);
    tiles_x_m1    = tx;
    tiles_y_m1    = ty;
    zclear_flag   = zc;
    wait_mode     = wmode;
    ra_gen_trig   = 1'b1;
    @(negedge clock);
    ra_gen_trig = 1'b0;
    check("busy_after_trig", 64'(ra_gen_busy), 64'd1);
    budget = 4 * exp_words + 100;
    for (int c = 0; c < budget; c++) begin
      @(negedge clock);
      if (retrig && c == 12) ra_gen_trig = 1'b1;
      if (retrig && c == 13) ra_gen_trig = 1'b0;
      if (c == abort_at) begin
        reset_n = 1'b0;
        #1;
        check("abort_wr", 64'(ra_vram_wr), 64'd0);
        check("abort_busy", 64'(ra_gen_busy), 64'd0);
        @(negedge clock);
        reset_n   = 1'b1;
        wait_mode = 0;
        exp_addr_q.delete();
        exp_data_q.delete();
        return;
      end
      #1;
      if (done_cnt > 0) break;
    end
    check("done_seen", 64'(done_cnt > 0), 64'd1);
    repeat (6) @(negedge clock);
    wait_mode = 0;
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("words_written", 64'(acc_cnt), 64'(exp_words));
    check("queue_drained", 64'(exp_addr_q.size()), 64'd0);
    check("idle_busy", 64'(ra_gen_busy), 64'd0);
    check("idle_wr", 64'(ra_vram_wr), 64'd0);
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  initial begin
    logic [9:0] nsz;
    reset_n       = 1'b0;
    ra_gen_trig   = 1'b0;
    REGION_BASE   = '0;
    OL_BASE       = '0;
    TA_ALLOC_CTRL = '0;
    FPU_PARAM_CFG = '0;
    tiles_x_m1    = '0;
    tiles_y_m1    = '0;
    zclear_flag   = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_wr", 64'(ra_vram_wr), 64'd0);
    check("rst_addr", 64'(ra_vram_addr), 64'd0);
    check("rst_dout", 64'(ra_vram_dout), 64'd0);
    check("rst_busy", 64'(ra_gen_busy), 64'd0);
    check("rst_done", 64'(ra_gen_done), 64'd0);
    check("rst_cnt", 64'(ra_entry_cnt), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // 1x1, v1, all lists size 1, zclear set.
    run_frame(6'd0, 6'd0, 24'h1000, 24'h8000, 10'b01_01_01_01_01, 1'b0, 1'b1, 0, 1'b0, -1);
    check("t1_ctrl", 64'(got_data[0]), 64'hC000_0000);
    check("t1_addr0", 64'(got_addr[0]), 64'h1000);
    check("t1_o", 64'(got_data[1]), 64'h8000);
    check("t1_om", 64'(got_data[2]), 64'h8020);
    check("t1_t", 64'(got_data[3]), 64'h8040);
    check("t1_tm", 64'(got_data[4]), 64'h8060);
    check("t1_addr4", 64'(got_addr[4]), 64'h1010);
    check("t1_cnt", 64'(ra_entry_cnt), 64'd1);

    // 2x1, v2, only pt enabled with size 2.
    run_frame(6'd1, 6'd0, 24'h2000, 24'h4000, 10'b10_00_00_00_00, 1'b1, 1'b0, 0, 1'b0, -1);
    check("t2_ctrl0", 64'(got_data[0]), 64'h0);
    check("t2_o_unused", 64'(got_data[1]), 64'h8000_0000);
    check("t2_pt0", 64'(got_data[5]), 64'h4000);
    check("t2_ctrl1", 64'(got_data[6]), 64'h8000_0004);
    check("t2_pt1", 64'(got_data[11]), 64'h4040);

    // Three-cycle stall on the third word.
    run_frame(6'd0, 6'd0, 24'h1000, 24'h8000, 10'b01_01_01_01_01, 1'b0, 1'b0, 2, 1'b0, -1);
    check("stall_cycles", 64'(stall_cnt), 64'd3);
    check("stall_word_addr", 64'(got_addr[2]), 64'h1008);

    // Re-trigger while busy must be ignored.
    run_frame(6'd2, 6'd1, 24'h3000, 24'h9000, 10'b11_10_01_00_11, 1'b1, 1'b1, 1, 1'b1, -1);

    // Reset mid-run, then a clean restart.
    run_frame(6'd3, 6'd3, 24'h5000, 24'hA000, 10'b01_01_01_01_01, 1'b1, 1'b0, 1, 1'b0, 15);
    check("post_abort_cnt", 64'(ra_entry_cnt), 64'd0);
    run_frame(6'd1, 6'd1, 24'h6000, 24'hB000, 10'b00_11_00_10_01, 1'b0, 1'b1, 1, 1'b0, -1);

    // Random frames, including address wrap near the 16MB boundary and all-lists-off.
    for (int i = 0; i < 8; i++) begin
      nsz = 10'($urandom());
      if (i == 3) nsz = '0;
      run_frame(6'($urandom_range(0, 4)), 6'($urandom_range(0, 3)),
                (i == 5) ? 24'hFFFFF0 : (24'($urandom()) & 24'hFFFFFC),
                (i == 6) ? 24'hFFFF00 : (24'($urandom()) & 24'hFFFFF0),
                nsz, 1'($urandom()), 1'($urandom()), 1, 1'b0, -1);
    end

    // Full 40x30 frame, v2, all lists size 3.
    run_frame(6'd39, 6'd29, 24'h10_0000, 24'h20_0000, 10'b11_11_11_11_11, 1'b1, 1'b0, 0,
              1'b0, -1);
`ifndef RA_WRITER_OL_INIT_EN
    check("big_words", 64'(got_data.size()), 64'd7200);
    check("big_last_ctrl", 64'(got_data[7194]), 64'h8000_1D9C);
`endif
    check("big_cnt", 64'(ra_entry_cnt), 64'd1200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
